// File: rtl/led_pwm_dimmer.sv
// LED output stage: PWM brightness and blink gating of an active-low LED
// pattern, with a four-word register window on the peripheral bus.
module led_pwm_dimmer #(
  parameter logic [31:0] DEVICE_START_ADDRESS = 32'h0000_1010,
  parameter logic [31:0] DEVICE_FINAL_ADDRESS = 32'h0000_101C,
  parameter int unsigned PRESCALE             = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        response,
  input  logic [7:0]  led_n_in,
  output logic [7:0]  led_n_out
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  // Register file
  logic        r_en;
  logic        r_blink_en;
  logic [7:0]  r_duty;
  logic [15:0] r_blink;

  // Bus response
  logic        r_response;
  logic [31:0] r_read_data;

  // Timing state
  logic [15:0] r_prescale;
  logic [7:0]  r_pwm_cnt;
  logic [15:0] r_blink_cnt;
  logic        r_blink_phase;
  logic [7:0]  r_led_n_out;

  logic [1:0]  w_offset;
  logic [31:0] w_rdata;
  logic        w_tick;
  logic        w_period_end;
  logic        w_pwm_on;
  logic        w_blink_run;
  logic        w_blink_shrink;
  logic        w_blink_wrap;
  logic        w_unused;

  // The interconnect qualifies the window, so only the word offset is decoded.
  assign w_offset = address[3:2];
  assign w_unused = ^{address[31:4], address[1:0], write_data[31:16],
                      DEVICE_START_ADDRESS, DEVICE_FINAL_ADDRESS};

  assign w_tick         = r_en && (r_prescale == PRESCALE_LAST);
  assign w_period_end   = w_tick && (r_pwm_cnt == 8'hFF);
  assign w_pwm_on       = (r_duty == 8'hFF) || (r_pwm_cnt < r_duty);
  assign w_blink_run    = r_en && r_blink_en && (r_blink != 16'd0);
  assign w_blink_shrink = write && (w_offset == 2'd2) &&
                          (write_data[15:0] < r_blink_cnt);
  // >= rather than == so a BLINK rewritten to exactly blink_cnt still wraps.
  assign w_blink_wrap   = (r_blink_cnt >= (r_blink - 16'd1));

  // Read multiplexer for the register window
  always_comb begin
    w_rdata = '0;
    case (w_offset)
      2'd0: w_rdata[1:0]  = {r_blink_en, r_en};
      2'd1: w_rdata[7:0]  = r_duty;
      2'd2: w_rdata[15:0] = r_blink;
      default: begin
        w_rdata[15:8] = r_pwm_cnt;
        w_rdata[0]    = r_blink_phase;
      end
    endcase
  end

  // Bus handshake and register writes; write wins over a simultaneous read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_response  <= 1'b0;
      r_read_data <= '0;
      r_en        <= 1'b0;
      r_blink_en  <= 1'b0;
      r_duty      <= 8'hFF;
      r_blink     <= '0;
    end else begin
      r_response  <= read | write;
      r_read_data <= (read && !write) ? w_rdata : '0;
      if (write) begin
        case (w_offset)
          2'd0: begin
            r_en       <= write_data[0];
            r_blink_en <= write_data[1];
          end
          2'd1: r_duty  <= write_data[7:0];
          2'd2: r_blink <= write_data[15:0];
          default: ;
        endcase
      end
    end
  end

  // Prescaler and PWM counter, both held at zero while disabled
  always_ff @(posedge clk) begin
    if (rst || !r_en) begin
      r_prescale <= '0;
      r_pwm_cnt  <= '0;
    end else if (w_tick) begin
      r_prescale <= '0;
      r_pwm_cnt  <= r_pwm_cnt + 8'd1;
    end else begin
      r_prescale <= r_prescale + 16'd1;
    end
  end

  // Blink half-period counter and phase, advanced once per PWM period
  always_ff @(posedge clk) begin
    if (rst || !w_blink_run) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_blink_shrink) begin
      r_blink_cnt   <= '0;
    end else if (w_period_end) begin
      if (w_blink_wrap) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + 16'd1;
      end
    end
  end

  // Registered LED pins: bypass when disabled, otherwise gated by PWM and blink
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led_n_out <= 8'hFF;
    end else if (!r_en) begin
      r_led_n_out <= led_n_in;
    end else begin
      r_led_n_out <= led_n_in | {8{~(w_pwm_on & ~r_blink_phase)}};
    end
  end

  assign read_data = r_read_data;
  assign response  = r_response;
  assign led_n_out = r_led_n_out;

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Directed bench for led_pwm_dimmer: bus accesses are scored through a queue,
// LED behaviour is checked by counting output patterns over PWM/blink periods.
module tb_led_pwm_dimmer;

  localparam logic [31:0] A_CTRL   = 32'h0000_1010;
  localparam logic [31:0] A_DUTY   = 32'h0000_1014;
  localparam logic [31:0] A_BLINK  = 32'h0000_1018;
  localparam logic [31:0] A_STATUS = 32'h0000_101C;
  localparam logic [31:0] ALL      = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        response;
  logic [7:0]  led_n_in;
  logic [7:0]  led_n_out;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    logic [31:0] mask;
  } sb_t;

  sb_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  led_pwm_dimmer #(
    .DEVICE_START_ADDRESS(32'h0000_1010),
    .DEVICE_FINAL_ADDRESS(32'h0000_101C),
    .PRESCALE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .read(read),
    .write(write),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .response(response),
    .led_n_in(led_n_in),
    .led_n_out(led_n_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every response pulse pops one expected entry.
  always @(negedge clk) begin
    sb_t e;
    if (response === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_response", {31'b0, response}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk(e.tag, read_data & e.mask, e.exp);
      end
    end
  end

  // One bus access: strobe for exactly one edge, response expected one cycle later.
  task automatic bus(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp,
                     input logic [31:0] mask, input string tag);
    sb_t e;
    e.tag = tag; e.exp = exp; e.mask = mask;
    sb.push_back(e);
    read = rd; write = wr; address = addr; write_data = wdata;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      chk({tag, "_noresp"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk); #1;
  endtask

  task automatic wait_val(input logic [7:0] v, input int unsigned bound, input string tag);
    for (int unsigned i = 0; i < bound; i++) begin
      @(negedge clk);
      if (led_n_out === v) return;
    end
    chk({tag, "_timeout"}, {24'b0, led_n_out}, {24'b0, v});
  endtask

  task automatic run_len(input logic [7:0] v, input int unsigned bound, output int unsigned n);
    n = 0;
    while (led_n_out === v && n < bound) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic window(input logic [7:0] v_on, input int unsigned len,
                        output int unsigned n_on, output int unsigned n_off,
                        output int unsigned n_other);
    n_on = 0; n_off = 0; n_other = 0;
    for (int unsigned i = 0; i < len; i++) begin
      @(negedge clk);
      if (led_n_out === v_on) n_on++;
      else if (led_n_out === 8'hFF) n_off++;
      else n_other++;
    end
  endtask

  initial begin
    int unsigned n_on, n_off, n_oth, n;
    rst = 1'b1; read = 1'b0; write = 1'b0; address = '0; write_data = '0;
    led_n_in = 8'hA5;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_led", {24'b0, led_n_out}, 32'h0000_00FF);
    chk("rst_response", {31'b0, response}, 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("bypass_after_rst", {24'b0, led_n_out}, 32'h0000_00A5);

    bus(1'b1, 1'b0, A_CTRL,   '0, 32'h0,  ALL, "rd_ctrl_rst");
    bus(1'b1, 1'b0, A_DUTY,   '0, 32'hFF, ALL, "rd_duty_rst");
    bus(1'b1, 1'b0, A_BLINK,  '0, 32'h0,  ALL, "rd_blink_rst");
    bus(1'b1, 1'b0, A_STATUS, '0, 32'h0,  ALL, "rd_status_rst");

    // Register access and handshake corner cases
    bus(1'b0, 1'b1, A_DUTY,   32'h3C, 32'h0,  ALL, "wr_duty");
    bus(1'b1, 1'b0, A_DUTY,   '0,     32'h3C, ALL, "rd_duty");
    bus(1'b1, 1'b1, A_CTRL,   32'h0,  32'h0,  ALL, "rdwr_ctrl");
    bus(1'b1, 1'b1, A_DUTY,   32'h3C, 32'h0,  ALL, "rdwr_duty");
    bus(1'b0, 1'b1, A_BLINK,  32'hABCD1234, 32'h0, ALL, "wr_blink");
    bus(1'b1, 1'b0, A_BLINK,  '0,     32'h1234, ALL, "rd_blink");
    bus(1'b0, 1'b1, A_STATUS, ALL,    32'h0,  ALL, "wr_status");
    bus(1'b1, 1'b0, A_STATUS, '0,     32'h0,  ALL, "rd_status_ro");
    bus(1'b0, 1'b1, A_BLINK,  32'h0,  32'h0,  ALL, "wr_blink0");

    // PWM duty: 64/256 of a 4096-cycle period lit
    led_n_in = 8'h00;
    bus(1'b0, 1'b1, A_DUTY, 32'h40, 32'h0, ALL, "wr_duty64");
    bus(1'b0, 1'b1, A_CTRL, 32'h1,  32'h0, ALL, "wr_en");
    window(8'h00, 4096, n_on, n_off, n_oth);
    chk("pwm64_on",  n_on,  32'd1024);
    chk("pwm64_off", n_off, 32'd3072);
    chk("pwm64_oth", n_oth, 32'd0);
    bus(1'b0, 1'b1, A_DUTY, 32'h00, 32'h0, ALL, "wr_duty0");
    window(8'h00, 4096, n_on, n_off, n_oth);
    chk("pwm0_off", n_off, 32'd4096);
    bus(1'b0, 1'b1, A_DUTY, 32'hFF, 32'h0, ALL, "wr_duty255");
    window(8'h00, 4096, n_on, n_off, n_oth);
    chk("pwm255_on", n_on, 32'd4096);

    // Blink: BLINK=2 toggles every two PWM periods
    led_n_in = 8'hF0;
    bus(1'b0, 1'b1, A_BLINK, 32'h2, 32'h0, ALL, "wr_blink2");
    bus(1'b0, 1'b1, A_CTRL,  32'h3, 32'h0, ALL, "wr_ctrl3");
    wait_val(8'hFF, 20000, "blink_first_off");
    run_len(8'hFF, 9000, n);
    chk("blink_off_len", n, 32'd8192);
    chk("blink_after_off", {24'b0, led_n_out}, 32'h0000_00F0);
    run_len(8'hF0, 9000, n);
    chk("blink_on_len", n, 32'd8192);
    bus(1'b1, 1'b0, A_STATUS, '0, 32'h1, 32'h1, "status_phase1");
    wait_val(8'hF0, 9000, "blink_back_on");
    bus(1'b1, 1'b0, A_STATUS, '0, 32'h0, 32'h1, "status_phase0");
    bus(1'b0, 1'b1, A_BLINK, 32'h0, 32'h0, ALL, "wr_blink_off");
    repeat (4) @(negedge clk);
    window(8'hF0, 8500, n_on, n_off, n_oth);
    chk("blink0_steady", n_on, 32'd8500);

    // Clearing EN mid-period returns to bypass and zeroes the counters
    bus(1'b0, 1'b1, A_DUTY, 32'h00, 32'h0, ALL, "wr_duty0_b");
    repeat (2000) @(negedge clk);
    chk("gated_off", {24'b0, led_n_out}, 32'h0000_00FF);
    bus(1'b0, 1'b1, A_CTRL, 32'h0, 32'h0, ALL, "wr_en_clear");
    chk("en_clear_bypass", {24'b0, led_n_out}, 32'h0000_00F0);
    led_n_in = 8'h3C;
    @(negedge clk);
    chk("bypass_latency", {24'b0, led_n_out}, 32'h0000_003C);
    bus(1'b1, 1'b0, A_STATUS, '0, 32'h0, ALL, "status_cleared");

    // Reset in the middle of blinking
    led_n_in = 8'hF0;
    bus(1'b0, 1'b1, A_DUTY,  32'hFF, 32'h0, ALL, "wr_duty_ff");
    bus(1'b0, 1'b1, A_BLINK, 32'h1,  32'h0, ALL, "wr_blink1");
    bus(1'b0, 1'b1, A_CTRL,  32'h3,  32'h0, ALL, "wr_ctrl3_b");
    wait_val(8'hFF, 10000, "blink1_off");
    wait_val(8'hF0, 6000,  "blink1_on");
    repeat (10) @(negedge clk);
    rst = 1'b1; read = 1'b1; address = A_CTRL;
    @(negedge clk);
    chk("midrst_led", {24'b0, led_n_out}, 32'h0000_00FF);
    chk("midrst_resp", {31'b0, response}, 32'd0);
    rst = 1'b0; read = 1'b0;
    @(negedge clk);
    chk("midrst_bypass", {24'b0, led_n_out}, 32'h0000_00F0);
    bus(1'b1, 1'b0, A_CTRL,   '0, 32'h0,  ALL, "midrst_ctrl");
    bus(1'b1, 1'b0, A_DUTY,   '0, 32'hFF, ALL, "midrst_duty");
    bus(1'b1, 1'b0, A_BLINK,  '0, 32'h0,  ALL, "midrst_blink");
    bus(1'b1, 1'b0, A_STATUS, '0, 32'h0,  ALL, "midrst_status");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_pwm_dimmer.md
Name: led_pwm_dimmer

Overview:
- Memory-mapped output stage placed directly downstream of the LED register peripheral.
- Consumes its active-low 8-bit LED pattern and drives the board LED pins.
- Applies global PWM brightness and optional blinking; bypass mode passes the pattern straight through.
- Sits on the same simple read/write/response peripheral bus as the other SoC peripherals.

Parameters:
- DEVICE_START_ADDRESS, 32'h00001010, base byte address of the register window.
- DEVICE_FINAL_ADDRESS, 32'h0000101C, last byte address of the window.
- PRESCALE, 16, clk cycles per PWM tick; legal range is 1 to 65535.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- read  input  1  bus read strobe, asserted by interconnect only when the address is in this window.
- write  input  1  bus write strobe, same qualification as read.
- address  input  32  byte address; only address[3:2] is decoded.
- write_data  input  32  write data.
- read_data  output  32  read data; valid while response is high, 0 otherwise.
- response  output  1  one-cycle acknowledge.
- led_n_in  input  8  active-low pattern from the LED register peripheral.
- led_n_out  output  8  active-low pins to the board LEDs.

Behaviour:
- Register map (word offset = address[3:2]):
  - 0 CTRL: bit0 EN, bit1 BLINK_EN; other bits read 0.
  - 1 DUTY: bits[7:0].
  - 2 BLINK: bits[15:0], half-period counted in PWM periods.
  - 3 STATUS (read-only): bit0 blink_phase, bits[15:8] pwm_cnt.
- Reset values: CTRL=0, DUTY=8'hFF, BLINK=0, pwm_cnt=0, prescaler=0, blink_cnt=0, blink_phase=0, response=0, read_data=0, led_n_out=8'hFF (all LEDs off).
- Bus handshake:
  - read or write sampled in cycle N produces response=1 in cycle N+1, for exactly one cycle.
  - read_data is registered in N and valid in N+1 together with response.
  - Write updates the register at the end of cycle N.
  - If read and write are both high, the write wins: one response pulse, read_data=0.
  - Write to offset 3 is ignored but still acknowledged.
  - Strobes held high for several cycles: each sampled cycle is a separate access, so response stays high.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - The wrap cycle asserts tick.
  - While EN=0, the prescaler and all PWM/blink counters are held at 0.
- PWM:
  - pwm_cnt is 8 bits and increments on tick, wrapping 255 to 0.
  - The wrap-on-tick cycle asserts period_end.
  - pwm_on = (pwm_cnt < DUTY), except DUTY=8'hFF, which forces pwm_on=1 (constant full on).
  - DUTY=0 gives always off.
  - A DUTY write takes effect immediately; no shadowing, so a glitch period is accepted.
- Blink:
  - With BLINK_EN=1 and BLINK!=0, blink_cnt increments on period_end.
  - When blink_cnt reaches BLINK-1 on period_end: blink_cnt goes to 0 and blink_phase toggles.
  - blink_phase=1 blanks all LEDs.
  - BLINK_EN=0 or BLINK=0: blink_cnt and blink_phase are cleared to 0 on the next cycle.
  - Writing BLINK below the current blink_cnt: blink_cnt is cleared to 0 in the same cycle as the write.
- Output, registered with 1-cycle latency from led_n_in:
  - EN=0: led_n_out <= led_n_in (pure bypass).
  - EN=1: led_n_out <= led_n_in | {8{~(pwm_on & ~blink_phase)}}, so an LED lights only when commanded low AND gated on.
- Reset mid-operation forces all reset values on the next edge, including led_n_out=8'hFF and dropping any pending response.

Test Plan:
- Reset then idle, led_n_in=8'hA5 -> led_n_out=8'hFF during reset, 8'hA5 one cycle after rst falls; reads of CTRL, DUTY, BLINK = 0, 8'hFF, 0.
- Write DUTY=8'h3C at cycle N, read it back -> response high only in N+1; read_data=32'h0000003C with response on the read; simultaneous read+write to CTRL -> single response pulse, read_data=0.
- PRESCALE=16, CTRL=1, DUTY=64, led_n_in=8'h00 -> over one PWM period (4096 clk), led_n_out=8'h00 for exactly 1024 clk and 8'hFF for 3072; DUTY=0 -> constant 8'hFF; DUTY=255 -> constant 8'h00.
- CTRL=3, BLINK=2, DUTY=255, led_n_in=8'hF0 -> output alternates 8'hF0 / 8'hFF every 2 PWM periods (8192 clk); STATUS bit0 tracks the phase; setting BLINK=0 -> steady 8'hF0.
- Clear EN mid-period -> next cycle led_n_out=led_n_in and STATUS reads 0; assert rst mid-blink -> led_n_out=8'hFF, CTRL=0 after one edge.
